// File: rtl/prio_enc_arb_if.sv
// Request/grant bundle for prio_enc_arb.
// slave = arbiter side, master = requester/consumer side.
interface prio_enc_arb_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         en;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic [W-1:0] ptr;

  modport slave (
    input  req,
    input  en,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot,
    output ptr
  );

  modport master (
    output req,
    output en,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    input  ptr
  );
endinterface

// File: rtl/prio_enc_arb.sv
// Registered N-way priority encoder / arbiter.
// Fixed (highest index wins) or round-robin mode.
module prio_enc_arb #(
  parameter int N       = 8,
  parameter bit RR_MODE = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  prio_enc_arb_if.slave bus
);
  localparam int W = $clog2(N);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] win;
  logic [N-1:0] win_oh;
  logic         load;

  // Descending search from base-1 with wrap; base is 0 in fixed mode.
  always_comb begin
    int base;
    int c;
    logic found;
    win   = '0;
    found = 1'b0;
    base  = RR_MODE ? int'(ptr_q) : 0;
    c     = 0;
    for (int s = 1; s <= N; s++) begin
      c = base - s;
      if (c < 0) c = c + N;
      if (!found && bus.req[c]) begin
        found = 1'b1;
        win   = W'(c);
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign load = bus.en && (|bus.req)
             && (!valid_q || bus.out_ready);

  // Next state: load replaces, accept clears, stall holds.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      idx_d   = win;
      oh_d    = win_oh;
      if (RR_MODE) ptr_d = win;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
      idx_d   = '0;
      oh_d    = '0;
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = oh_q;
  assign bus.ptr        = ptr_q;
endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb: three instances
// (N=4 fixed, N=4 rr, N=5 rr) vs a reference model.
module tb_prio_enc_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] r   [3];
  logic        e   [3];
  logic        rdy [3];

  int nn  [3] = '{4, 4, 5};
  bit rrm [3] = '{1'b0, 1'b1, 1'b1};

  int mv [3];
  int mi [3];
  int mp [3];

  int tests = 0;
  int fails = 0;

  prio_enc_arb_if #(.N(4)) i4f ();
  prio_enc_arb_if #(.N(4)) i4r ();
  prio_enc_arb_if #(.N(5)) i5r ();

  assign i4f.req       = r[0][3:0];
  assign i4f.en        = e[0];
  assign i4f.out_ready = rdy[0];
  assign i4r.req       = r[1][3:0];
  assign i4r.en        = e[1];
  assign i4r.out_ready = rdy[1];
  assign i5r.req       = r[2][4:0];
  assign i5r.en        = e[2];
  assign i5r.out_ready = rdy[2];

  prio_enc_arb #(.N(4), .RR_MODE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(i4f));
  prio_enc_arb #(.N(4), .RR_MODE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i4r));
  prio_enc_arb #(.N(5), .RR_MODE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(i5r));

  task automatic ck(input string tag,
                    input logic [63:0] got,
                    input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic int winner(input int k);
    int base;
    int c;
    base = rrm[k] ? mp[k] : 0;
    for (int s = 1; s <= nn[k]; s++) begin
      c = (base - s + nn[k]) % nn[k];
      if (r[k][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0;
      mi[k] = 0;
      mp[k] = 0;
    end
  endtask

  task automatic model_edge();
    int w;
    bit any;
    bit ld;
    for (int k = 0; k < 3; k++) begin
      any = 1'b0;
      for (int b = 0; b < nn[k]; b++)
        if (r[k][b]) any = 1'b1;
      ld = e[k] && any && (mv[k] == 0 || rdy[k]);
      if (ld) begin
        w = winner(k);
        mv[k] = 1;
        mi[k] = w;
        if (rrm[k]) mp[k] = w;
      end else if (mv[k] != 0 && rdy[k]) begin
        mv[k] = 0;
        mi[k] = 0;
      end
    end
  endtask

  task automatic get(input int k,
                     output logic [63:0] v,
                     output logic [63:0] ix,
                     output logic [63:0] oh,
                     output logic [63:0] p);
    v = '0; ix = '0; oh = '0; p = '0;
    case (k)
      0: begin
        v = 64'(i4f.out_valid); ix = 64'(i4f.out_idx);
        oh = 64'(i4f.out_onehot); p = 64'(i4f.ptr);
      end
      1: begin
        v = 64'(i4r.out_valid); ix = 64'(i4r.out_idx);
        oh = 64'(i4r.out_onehot); p = 64'(i4r.ptr);
      end
      default: begin
        v = 64'(i5r.out_valid); ix = 64'(i5r.out_idx);
        oh = 64'(i5r.out_onehot); p = 64'(i5r.ptr);
      end
    endcase
  endtask

  task automatic check_all();
    logic [63:0] v, ix, oh, p, eoh;
    for (int k = 0; k < 3; k++) begin
      get(k, v, ix, oh, p);
      eoh = (mv[k] != 0) ? (64'd1 << mi[k]) : 64'd0;
      ck($sformatf("u%0d valid", k), v, 64'(mv[k]));
      ck($sformatf("u%0d idx", k), ix, 64'(mi[k]));
      ck($sformatf("u%0d onehot", k), oh, eoh);
      ck($sformatf("u%0d ptr", k), p, 64'(mp[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [63:0] rq,
                       input logic en,
                       input logic rd);
    for (int k = 0; k < 3; k++) begin
      r[k]   = rq & ((64'd1 << nn[k]) - 64'd1);
      e[k]   = en;
      rdy[k] = rd;
    end
  endtask

  // Async reset asserted mid-cycle, released on the falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int s4 [6] = '{3, 2, 1, 0, 3, 2};
  int s5 [6] = '{4, 3, 2, 1, 0, 4};
  int p5 [3] = '{0, 2, 0};

  initial begin
    model_reset();
    drive(64'd0, 1'b0, 1'b0);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed-priority patterns
    drive(64'h1, 1'b1, 1'b1);
    step();
    ck("fix req0001 valid", 64'(i4f.out_valid), 64'd1);
    ck("fix req0001 idx", 64'(i4f.out_idx), 64'd0);
    ck("fix req0001 oh", 64'(i4f.out_onehot), 64'h1);
    drive(64'h2, 1'b1, 1'b1);
    step();
    ck("fix req0010", 64'(i4f.out_idx), 64'd1);
    drive(64'h4, 1'b1, 1'b1);
    step();
    ck("fix req0100", 64'(i4f.out_idx), 64'd2);
    drive(64'h8, 1'b1, 1'b1);
    step();
    ck("fix req1000", 64'(i4f.out_idx), 64'd3);
    drive(64'hB, 1'b1, 1'b1);
    step();
    ck("fix req1011", 64'(i4f.out_idx), 64'd3);

    // Round-robin rotation from a clean pointer
    do_reset();
    drive(64'h1F, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      ck($sformatf("rr4 seq%0d", i),
         64'(i4r.out_idx), 64'(s4[i]));
      ck($sformatf("rr4 ptr%0d", i),
         64'(i4r.ptr), 64'(s4[i]));
      ck($sformatf("rr5 seq%0d", i),
         64'(i5r.out_idx), 64'(s5[i]));
    end
    drive(64'h5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      ck($sformatf("rr4 0101 #%0d", i),
         64'(i4r.out_idx), 64'(p5[i]));
    end

    // Backpressure
    drive(64'h4, 1'b1, 1'b1);
    step();
    ck("bp grant", 64'(i4r.out_idx), 64'd2);
    drive(64'h4, 1'b1, 1'b0);
    step();
    drive(64'h3, 1'b1, 1'b0);
    step();
    step();
    ck("bp hold idx", 64'(i4r.out_idx), 64'd2);
    ck("bp hold valid", 64'(i4r.out_valid), 64'd1);
    ck("bp hold ptr", 64'(i4r.ptr), 64'd2);
    drive(64'h3, 1'b1, 1'b1);
    step();
    ck("bp release", 64'(i4r.out_idx), 64'd1);

    // Drain and en=0
    drive(64'h0, 1'b1, 1'b1);
    step();
    ck("drain valid", 64'(i4r.out_valid), 64'd0);
    ck("drain oh", 64'(i4r.out_onehot), 64'd0);
    drive(64'h1F, 1'b0, 1'b1);
    step();
    step();
    ck("en0 valid", 64'(i4f.out_valid), 64'd0);
    drive(64'h1, 1'b1, 1'b1);
    step();
    drive(64'h1, 1'b0, 1'b0);
    step();
    ck("en0 held", 64'(i4f.out_valid), 64'd1);
    drive(64'h1, 1'b0, 1'b1);
    step();
    ck("en0 drop", 64'(i4f.out_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 3; k++) begin
        r[k] = 64'($urandom)
             & ((64'd1 << nn[k]) - 64'd1);
        if ($urandom_range(0, 5) == 0) r[k] = '0;
        e[k]   = ($urandom_range(0, 7) != 0);
        rdy[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 60) == 0) do_reset();
      step();
      ck("rr5 range", 64'(i5r.out_idx < 3'd5), 64'd1);
    end

    // Async reset mid-stall with ptr=3
    drive(64'h0, 1'b0, 1'b1);
    step();
    do_reset();
    drive(64'h8, 1'b1, 1'b1);
    step();
    ck("pre-rst ptr", 64'(i4r.ptr), 64'd3);
    drive(64'h8, 1'b1, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    ck("arst valid", 64'(i4r.out_valid), 64'd0);
    ck("arst idx", 64'(i4r.out_idx), 64'd0);
    ck("arst oh", 64'(i4r.out_onehot), 64'd0);
    ck("arst ptr", 64'(i4r.ptr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(64'hF, 1'b1, 1'b1);
    step();
    ck("post-rst fix", 64'(i4f.out_idx), 64'd3);
    ck("post-rst rr", 64'(i4r.out_idx), 64'd3);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end
endmodule
